decode_queue: RTL and testbench
===============================

DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter INST_W, default 9, instruction width in bits.
REQ-002 Parameter OPC_W, default 3, opcode field width, taken from in_inst[INST_W-1 -: OPC_W].
REQ-003 Parameter FUN_W, default 2, function field width, taken from the bits directly below the opcode.
REQ-004 Parameter DEPTH, default 2, queue entries; power of two, at least 2.
REQ-005 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-006 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  sole clock; all state updates on the rising edge.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 in_valid  in  1  upstream instruction present.
REQ-010 in_ready  out  1  queue accepts in_inst this cycle.
REQ-011 in_inst  in  INST_W  raw instruction word.
REQ-012 flush  in  1  discard all queued entries (branch taken).
REQ-013 resume  in  1  leave the HALTED state.
REQ-014 out_valid  out  1  head entry is valid.
REQ-015 out_ready  in  1  downstream consumes the head entry.
REQ-016 out_opcode  out  OPC_W  Opcode of the head entry.
REQ-017 out_type  out  2  InstType of the head entry.
REQ-018 out_fun  out  FUN_W  function field of the head entry.
REQ-019 out_operand  out  INST_W-OPC_W-FUN_W  remaining low bits of the head entry.
REQ-020 out_halt  out  1  head entry is a HALT.
REQ-021 halted  out  1  state is HALTED.
REQ-022 inst_count  out  CNT_W  number of entries popped since reset.

Function
REQ-023 Push: in_valid && in_ready && !flush writes the decoded entry at the tail.
REQ-024 Pop: out_valid && out_ready removes the head entry.
REQ-025 Decode at push: opcode maps R_ADD=0, I_LW=1, I_SW=2, B_BEQ=3, M_MOV=4, R_SHF=5, R_NEG=6, I_SET=7.
REQ-026 Type mapping: LW, SW and SET decode to I; MOV decodes to M; BEQ decodes to B; ADD, SHF and NEG decode to R.
REQ-027 HALT decode: halt is set when opcode == R_NEG and fun == FUN_HALT.
REQ-028 Latency: an entry pushed at edge N appears on out_* at N+1 when the queue was empty; there is no combinational in-to-out path.
REQ-029 in_ready = !full && state == RUN; a push into a full queue does not occur, even when a pop happens in the same cycle.
REQ-030 A simultaneous push and pop on a non-full, non-empty queue leaves the occupancy unchanged.
REQ-031 Pointers wrap modulo DEPTH; occupancy is tracked with one extra bit so that full and empty are distinct.
REQ-032 out_* fields are held stable while out_valid && !out_ready.
REQ-033 State RUN goes to DRAIN on pushing a HALT entry; no further pushes are accepted.
REQ-034 State DRAIN goes to HALTED on popping the HALT entry.
REQ-035 State HALTED goes to RUN on resume; resume is ignored in RUN and DRAIN.
REQ-036 Flush empties the queue at the edge, and flush wins over a same-cycle push or pop.
REQ-037 Flush in DRAIN returns the state to RUN; flush in RUN or HALTED leaves the state unchanged.
REQ-038 inst_count increments by 1 per pop, including the HALT pop, and saturates at 2^CNT_W-1.
REQ-039 inst_count does not change on flush.

Reset
REQ-040 rst_n low at an edge sets the state to RUN, empties the queue and sets inst_count to 0.
REQ-041 While reset is applied: out_valid=0, out_halt=0, halted=0, in_ready=0; in_ready rises on the first edge after rst_n high.
REQ-042 Reset mid-operation (any state, any occupancy) discards all entries; no pop is counted.

Structure
REQ-043 The shared package holds the Opcode enum (values as in REQ-025), InstType {I,M,B,R}, the FUN_* constants, a packed decoded-entry struct and the state enum {RUN,DRAIN,HALTED}.
REQ-044 Combinational decode sits in one sub-module, inst_decoder, instantiated on the push path.

Verification
REQ-045 Reset, then push ADD (000_00_xxxx) -> next cycle out_valid=1, out_type=R, out_fun=0.
REQ-046 Push 3 entries with DEPTH=2 and out_ready=0 -> in_ready=0 after 2 pushes, third held; out_ready=1 -> order preserved, inst_count=3.
REQ-047 Push SET then HALT (110_11_0000) -> state DRAIN, in_ready=0; pop both -> halted=1; resume -> halted=0, in_ready=1.
REQ-048 Two entries queued plus same-cycle flush and push -> next cycle out_valid=0, inst_count unchanged, the pushed entry is absent.
REQ-049 HALT queued (DRAIN) then flush -> state RUN, halted never asserts.
REQ-050 CNT_W=2, 5 pops -> inst_count sequence 1,2,3,3,3; rst_n low mid-stream -> all outputs 0 next edge.

Source files
------------

// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: opcode and instruction-type encodings,
// function-field constants, per-entry decode flags and the control state set.
package decode_queue_pkg;

  typedef enum logic [2:0] {
    R_ADD = 3'd0,
    I_LW  = 3'd1,
    I_SW  = 3'd2,
    B_BEQ = 3'd3,
    M_MOV = 3'd4,
    R_SHF = 3'd5,
    R_NEG = 3'd6,
    I_SET = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    TYPE_I = 2'd0,
    TYPE_M = 2'd1,
    TYPE_B = 2'd2,
    TYPE_R = 2'd3
  } inst_type_e;

  localparam logic [1:0] FUN_BASE = 2'b00;
  localparam logic [1:0] FUN_HALT = 2'b11;

  // Decode results stored alongside the raw fields of each queue entry.
  typedef struct packed {
    inst_type_e itype;
    logic       halt;
  } dec_info_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  function automatic inst_type_e type_of(input opcode_e op);
    case (op)
      I_LW, I_SW, I_SET: return TYPE_I;
      M_MOV:             return TYPE_M;
      B_BEQ:             return TYPE_B;
      default:           return TYPE_R;
    endcase
  endfunction

endpackage

// File: rtl/decode_queue_inst_decoder.sv
// Purely combinational field split and classification of one raw instruction.
module inst_decoder
  import decode_queue_pkg::*;
#(
  parameter int INST_W = 9,
  parameter int OPC_W  = 3,
  parameter int FUN_W  = 2
) (
  input  logic [INST_W-1:0]             inst,
  output logic [OPC_W-1:0]              opcode,
  output logic [FUN_W-1:0]              fun,
  output logic [INST_W-OPC_W-FUN_W-1:0] operand,
  output dec_info_t                     info
);

  opcode_e op;

  assign opcode  = inst[INST_W-1 -: OPC_W];
  assign fun     = inst[INST_W-OPC_W-1 -: FUN_W];
  assign operand = inst[INST_W-OPC_W-FUN_W-1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    op         = opcode_e'(3'(opcode));
    info       = '0;
    info.itype = type_of(op);
    info.halt  = (op == R_NEG) && (fun == FUN_W'(FUN_HALT));
  end

endmodule

// File: rtl/decode_queue.sv
// Instruction decode queue: decodes on push, holds up to DEPTH entries and
// stops accepting after a HALT until it has drained and resume is seen.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int INST_W = 9,
  parameter int OPC_W  = 3,
  parameter int FUN_W  = 2,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INST_W-1:0]             in_inst,
  input  logic                          flush,
  input  logic                          resume,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OPC_W-1:0]              out_opcode,
  output logic [1:0]                    out_type,
  output logic [FUN_W-1:0]              out_fun,
  output logic [INST_W-OPC_W-FUN_W-1:0] out_operand,
  output logic                          out_halt,
  output logic                          halted,
  output logic [CNT_W-1:0]              inst_count
);

  localparam int OPR_W = INST_W - OPC_W - FUN_W;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_DRAIN  = DRAIN;
  localparam logic [1:0] ST_HALTED = HALTED;

  logic [OPC_W-1:0] dec_opcode;
  logic [FUN_W-1:0] dec_fun;
  logic [OPR_W-1:0] dec_operand;
  dec_info_t        dec_info;

  inst_decoder #(
    .INST_W (INST_W),
    .OPC_W  (OPC_W),
    .FUN_W  (FUN_W)
  ) u_decoder (
    .inst    (in_inst),
    .opcode  (dec_opcode),
    .fun     (dec_fun),
    .operand (dec_operand),
    .info    (dec_info)
  );

  logic [OPC_W-1:0] opc_mem  [DEPTH];
  logic [FUN_W-1:0] fun_mem  [DEPTH];
  logic [OPR_W-1:0] opr_mem  [DEPTH];
  dec_info_t        info_mem [DEPTH];

  // Pointers carry one bit beyond the index so full and empty stay distinct.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    head;
  logic             empty;
  logic             full;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             ready_en;
  logic             push;
  logic             pop;

  assign head  = rd_ptr[AW-1:0];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // ready_en keeps in_ready low throughout reset and for the release edge itself.
  assign in_ready  = ready_en && !full && (state == ST_RUN);
  assign out_valid = !empty;
  assign halted    = (state == ST_HALTED);

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // Fields read zero when nothing is queued, so stale storage never leaks out.
  assign out_opcode  = out_valid ? opc_mem[head]        : '0;
  assign out_fun     = out_valid ? fun_mem[head]        : '0;
  assign out_operand = out_valid ? opr_mem[head]        : '0;
  assign out_type    = out_valid ? info_mem[head].itype : TYPE_I;
  assign out_halt    = out_valid && info_mem[head].halt;

  // NOTE: storage is not reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      opc_mem[wr_ptr[AW-1:0]]  <= dec_opcode;
      fun_mem[wr_ptr[AW-1:0]]  <= dec_fun;
      opr_mem[wr_ptr[AW-1:0]]  <= dec_operand;
      info_mem[wr_ptr[AW-1:0]] <= dec_info;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      if (state == ST_DRAIN) state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_RUN:    if (push && dec_info.halt)             state_nxt = ST_DRAIN;
        ST_DRAIN:  if (pop && info_mem[head].halt)        state_nxt = ST_HALTED;
        ST_HALTED: if (resume)                            state_nxt = ST_RUN;
        default:                                          state_nxt = ST_RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      state      <= ST_RUN;
      ready_en   <= 1'b0;
      inst_count <= '0;
    end else begin
      ready_en <= 1'b1;
      state    <= state_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (pop && (inst_count != '1)) inst_count <= inst_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench: directed scenarios plus random traffic, compared each
// cycle against a queue-based behavioural model of the decode queue.
module tb_decode_queue;

  localparam int INST_W = 9;
  localparam int OPC_W  = 3;
  localparam int FUN_W  = 2;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 2;
  localparam int OPR_W  = INST_W - OPC_W - FUN_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [INST_W-1:0] in_inst = '0;
  logic              flush = 1'b0;
  logic              resume = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OPC_W-1:0]  out_opcode;
  logic [1:0]        out_type;
  logic [FUN_W-1:0]  out_fun;
  logic [OPR_W-1:0]  out_operand;
  logic              out_halt;
  logic              halted;
  logic [CNT_W-1:0]  inst_count;

  decode_queue #(
    .INST_W (INST_W),
    .OPC_W  (OPC_W),
    .FUN_W  (FUN_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .flush       (flush),
    .resume      (resume),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_type    (out_type),
    .out_fun     (out_fun),
    .out_operand (out_operand),
    .out_halt    (out_halt),
    .halted      (halted),
    .inst_count  (inst_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a plain queue of raw words plus a coarse state number
  // (0 = accepting, 1 = draining after HALT, 2 = halted).
  int m_q[$];
  int m_st = 0;
  int m_cnt = 0;
  bit m_ready_en = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int opc_of(input int w);  return (w >> 6) & 7;  endfunction
  function automatic int fun_of(input int w);  return (w >> 4) & 3;  endfunction
  function automatic int opr_of(input int w);  return w & 15;        endfunction
  function automatic bit is_halt(input int w); return opc_of(w) == 6 && fun_of(w) == 3; endfunction

  // LW/SW/SET -> I(0), MOV -> M(1), BEQ -> B(2), ADD/SHF/NEG -> R(3)
  function automatic int type_of_op(input int op);
    case (op)
      1, 2, 7: return 0;
      4:       return 1;
      3:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit m_in_ready();
    return m_ready_en && (m_q.size() < DEPTH) && (m_st == 0);
  endfunction

  task automatic compare_all();
    bit v;
    int h;
    v = (m_q.size() > 0);
    h = v ? m_q[0] : 0;
    check("in_ready",    32'(in_ready),    32'(m_in_ready()));
    check("out_valid",   32'(out_valid),   32'(v));
    check("out_opcode",  32'(out_opcode),  v ? opc_of(h) : 0);
    check("out_type",    32'(out_type),    v ? type_of_op(opc_of(h)) : 0);
    check("out_fun",     32'(out_fun),     v ? fun_of(h) : 0);
    check("out_operand", 32'(out_operand), v ? opr_of(h) : 0);
    check("out_halt",    32'(out_halt),    32'(v && is_halt(h)));
    check("halted",      32'(halted),      32'(m_st == 2));
    check("inst_count",  32'(inst_count),  m_cnt);
  endtask

  // Advance the model on the current inputs, clock once, then compare.
  task automatic step();
    bit do_push, do_pop, head_halt;
    if (!rst_n) begin
      m_q.delete();
      m_st = 0;
      m_cnt = 0;
      m_ready_en = 0;
    end else begin
      do_push   = in_valid && m_in_ready();
      do_pop    = (m_q.size() > 0) && out_ready;
      head_halt = (m_q.size() > 0) && is_halt(m_q[0]);
      m_ready_en = 1;
      if (flush) begin
        m_q.delete();
        if (m_st == 1) m_st = 0;
      end else begin
        if (do_pop) begin
          void'(m_q.pop_front());
          if (m_cnt < CNT_MAX) m_cnt++;
        end
        if (do_push) m_q.push_back(int'(in_inst));
        if (m_st == 0 && do_push && is_halt(int'(in_inst))) m_st = 1;
        else if (m_st == 1 && do_pop && head_halt)          m_st = 2;
        else if (m_st == 2 && resume)                       m_st = 0;
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic drive(input bit rn, input bit v, input int inst, input bit fl,
                       input bit rs, input bit ordy);
    rst_n     = rn;
    in_valid  = v;
    in_inst   = INST_W'(inst);
    flush     = fl;
    resume    = rs;
    out_ready = ordy;
    step();
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, ordy);
  endtask

  localparam int W_ADD  = 9'b000_00_0101;
  localparam int W_LW   = 9'b001_01_1010;
  localparam int W_MOV  = 9'b100_10_0011;
  localparam int W_BEQ  = 9'b011_00_1111;
  localparam int W_SET  = 9'b111_00_0000;
  localparam int W_HALT = 9'b110_11_0000;

  initial begin
    // Reset held for two edges: everything quiet, in_ready still low.
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, W_ADD, 0, 0, 0);
    check("rst_in_ready", 32'(in_ready), 0);
    idle(1, 0);
    check("ready_after_release", 32'(in_ready), 1);

    // Single ADD appears one edge after the push.
    drive(1, 1, W_ADD, 0, 0, 0);
    check("add_valid", 32'(out_valid), 1);
    check("add_type",  32'(out_type), 3);
    check("add_fun",   32'(out_fun), 0);
    idle(1, 1);

    // Fill a two-entry queue, hold a third, then drain in order.
    drive(0, 0, 0, 0, 0, 0);
    idle(1, 0);
    drive(1, 1, W_LW, 0, 0, 0);
    drive(1, 1, W_MOV, 0, 0, 0);
    drive(1, 1, W_BEQ, 0, 0, 0);
    check("full_in_ready", 32'(in_ready), 0);
    drive(1, 1, W_BEQ, 0, 0, 1);
    drive(1, 1, W_BEQ, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    check("three_count", 32'(inst_count), 3);
    idle(1, 0);

    // SET then HALT: drain, halt, resume.
    drive(0, 0, 0, 0, 0, 0);
    idle(1, 0);
    drive(1, 1, W_SET, 0, 0, 0);
    drive(1, 1, W_HALT, 0, 0, 0);
    check("drain_in_ready", 32'(in_ready), 0);
    drive(1, 1, W_ADD, 0, 1, 1);
    drive(1, 1, W_ADD, 0, 1, 1);
    check("halted_set", 32'(halted), 1);
    drive(1, 0, 0, 0, 1, 0);
    check("resume_halted", 32'(halted), 0);
    check("resume_in_ready", 32'(in_ready), 1);

    // Flush beats a same-cycle push; count unchanged.
    drive(1, 1, W_LW, 0, 0, 0);
    drive(1, 1, W_MOV, 0, 0, 0);
    drive(1, 1, W_BEQ, 1, 0, 1);
    check("flush_valid", 32'(out_valid), 0);
    idle(1, 0);

    // Flush while draining returns to accepting without halting.
    drive(1, 1, W_HALT, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    check("flush_drain_halted", 32'(halted), 0);
    check("flush_drain_ready", 32'(in_ready), 1);
    idle(2, 1);

    // Counter saturation over a streamed run of pops, then mid-stream reset.
    drive(0, 0, 0, 0, 0, 0);
    idle(1, 0);
    for (int i = 0; i < 6; i++) drive(1, 1, W_ADD + i, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 1);
    check("sat_count", 32'(inst_count), CNT_MAX);
    drive(1, 1, W_MOV, 0, 0, 0);
    drive(1, 1, W_LW, 0, 0, 0);
    drive(0, 1, W_SET, 0, 0, 1);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_count", 32'(inst_count), 0);
    check("midrst_opcode", 32'(out_opcode), 0);
    idle(1, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int w;
      w = int'($urandom_range(0, 511));
      if ($urandom_range(0, 7) == 0) w = W_HALT | int'($urandom_range(0, 15));
      drive($urandom_range(0, 99) != 0,
            $urandom_range(0, 9) < 6,
            w,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
